// File: rtl/phv_queue_dispatcher.sv
// phv_queue_dispatcher
//
// Takes one PHV at a time from the last match-action stage and hands a copy
// to every output queue named in the PHV's queue mask. Each queue has its own
// ready/valid handshake, and the queues are served in parallel. The held PHV
// is released in one of three ways:
//   - every selected queue has accepted it,
//   - the mask was empty, in which case it is dropped on entry,
//   - no queue made progress for STALL_LIMIT cycles (forced drop).
//
// Ports:
//   axis_clk        single clock
//   aresetn         synchronous reset, active high (1 = reset)
//   phv_in          incoming PHV; queue mask at [QMASK_OFF +: C_NUM_QUEUES]
//   phv_in_valid    phv_in is valid
//   phv_in_ready    block accepts phv_in this cycle
//   phv_out         latched PHV, shared by all queues
//   phv_out_valid   bit i = PHV offered to queue i
//   phv_fifo_ready  bit i = queue i can accept
//   pkt_cnt         PHVs fully delivered
//   drop_cnt        PHVs dropped because the mask was zero
//   timeout_cnt     PHVs abandoned by the stall timeout
//   busy            a PHV is being dispatched

module phv_queue_dispatcher #(
    parameter int PHV_LEN      = 1024,
    parameter int C_NUM_QUEUES = 4,
    parameter int QMASK_OFF    = 141,
    parameter int STALL_LIMIT  = 1024,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    axis_clk,
    input  logic                    aresetn,
    input  logic [PHV_LEN-1:0]      phv_in,
    input  logic                    phv_in_valid,
    output logic                    phv_in_ready,
    output logic [PHV_LEN-1:0]      phv_out,
    output logic [C_NUM_QUEUES-1:0] phv_out_valid,
    input  logic [C_NUM_QUEUES-1:0] phv_fifo_ready,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic [CNT_WIDTH-1:0]    timeout_cnt,
    output logic                    busy
);

    typedef enum logic {
        IDLE,
        DISPATCH
    } state_t;

    // Last stall count value before the forced drop fires. With the timeout
    // disabled the comparison is gated off, so the wrapped value is harmless.
    localparam logic [15:0]          STALL_LAST = 16'(STALL_LIMIT - 1);
    localparam bit                   TIMEOUT_EN = (STALL_LIMIT != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                  state;
    state_t                  state_next;
    logic [C_NUM_QUEUES-1:0] pending;
    logic [C_NUM_QUEUES-1:0] pending_next;
    logic [C_NUM_QUEUES-1:0] done;
    logic [C_NUM_QUEUES-1:0] mask_in;
    logic [15:0]             stall_cnt;
    logic [15:0]             stall_next;
    logic                    accept;
    logic                    inc_pkt;
    logic                    inc_drop;
    logic                    inc_timeout;

    // Only the low C_NUM_QUEUES bits of the mask field are meaningful.
    assign mask_in       = phv_in[QMASK_OFF +: C_NUM_QUEUES];
    assign done          = pending & phv_fifo_ready;
    assign phv_out_valid = (state == DISPATCH) ? pending : '0;
    assign busy          = (state == DISPATCH);
    assign accept        = phv_in_valid & phv_in_ready;

    // Ready is combinational on phv_fifo_ready so that a new PHV can be taken
    // in the same cycle the held one finishes, giving one PHV per cycle.
    always_comb begin
        phv_in_ready = 1'b0;
        if (!aresetn) begin
            if (state == IDLE) begin
                phv_in_ready = 1'b1;
            end else if ((pending & ~phv_fifo_ready) == '0) begin
                phv_in_ready = 1'b1;
            end
        end
    end

    // Next-state logic: retire served queues, run the stall timer, and let a
    // same-cycle accept override whatever the held PHV would have done.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        stall_next   = stall_cnt;
        inc_pkt      = 1'b0;
        inc_drop     = 1'b0;
        inc_timeout  = 1'b0;

        case (state)
            IDLE: begin
            end
            DISPATCH: begin
                pending_next = pending & ~done;
                if ((pending & ~done) == '0) begin
                    inc_pkt    = 1'b1;
                    state_next = IDLE;
                end else if (done != '0) begin
                    stall_next = '0;
                end else if (TIMEOUT_EN && (stall_cnt == STALL_LAST)) begin
                    // Queues already served keep their copy; the rest miss it.
                    pending_next = '0;
                    inc_timeout  = 1'b1;
                    state_next   = IDLE;
                end else begin
                    stall_next = stall_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            pending_next = mask_in;
            stall_next   = '0;
            if (mask_in == '0) begin
                inc_drop   = 1'b1;
                state_next = IDLE;
            end else begin
                state_next = DISPATCH;
            end
        end
    end

    // State, held PHV and statistics registers.
    always_ff @(posedge axis_clk) begin
        if (aresetn) begin
            state       <= IDLE;
            pending     <= '0;
            stall_cnt   <= '0;
            phv_out     <= '0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            stall_cnt <= stall_next;
            if (accept) begin
                phv_out <= phv_in;
            end
            if (inc_pkt) begin
                pkt_cnt <= pkt_cnt + CNT_ONE;
            end
            if (inc_drop) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
            if (inc_timeout) begin
                timeout_cnt <= timeout_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/phv_queue_dispatcher.md
# phv_queue_dispatcher

Sits between the last match-action stage and the per-queue output PHV FIFOs. It takes one PHV at a time and reads its queue mask, PHV bits `[QMASK_OFF +: C_NUM_QUEUES]`, with one bit per output queue. It delivers the PHV to every selected queue, each under its own ready/valid handshake. The PHV is consumed only when all selected queues have accepted it, when the mask is empty (drop), or when a stall timeout expires.

## Interface
- `PHV_LEN`, 1024: PHV width; 48*8+32*8+16*8+256.
- `C_NUM_QUEUES`, 4: number of output queues, 1..8.
- `QMASK_OFF`, 141: LSB position of the queue mask inside the PHV.
- `STALL_LIMIT`, 1024: no-progress cycles before forced drop; 0 disables the timeout; 16-bit.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `axis_clk` in 1: the single clock.
- `aresetn` in 1: reset; synchronous, active-high (1 = reset).
- `phv_in` in PHV_LEN: input PHV.
- `phv_in_valid` in 1: `phv_in` is valid.
- `phv_in_ready` out 1: the block accepts `phv_in` this cycle.
- `phv_out` out PHV_LEN: latched PHV, shared by all queues.
- `phv_out_valid` out C_NUM_QUEUES: bit i = offer to queue i.
- `phv_fifo_ready` in C_NUM_QUEUES: bit i = queue i can accept.
- `pkt_cnt` out CNT_WIDTH: PHVs fully delivered.
- `drop_cnt` out CNT_WIDTH: PHVs dropped because the mask was zero.
- `timeout_cnt` out CNT_WIDTH: PHVs abandoned by timeout.
- `busy` out 1: the block is in DISPATCH.

## Operation
- States:
  - IDLE: no held PHV.
  - DISPATCH: PHV held, `pending` mask non-zero.
- Accept: an input is accepted when `phv_in_valid & phv_in_ready`.
- `phv_in_ready` = (state==IDLE) | (state==DISPATCH & (pending & ~phv_fifo_ready)==0). The second term is combinational on `phv_fifo_ready` and covers the completing cycle.
- On accept:
  - `phv_out` <= `phv_in`.
  - `pending` <= `phv_in[QMASK_OFF +: C_NUM_QUEUES]`; mask bits above C_NUM_QUEUES are ignored.
  - Mask zero: `drop_cnt`++, next state IDLE, no output asserted.
  - Mask non-zero: next state DISPATCH, `stall_cnt` <= 0.
- In DISPATCH:
  - `phv_out_valid` = `pending`.
  - Per cycle: `done` = `pending & phv_fifo_ready`; `pending` <= `pending & ~done`. Delivery to all ready queues happens in parallel.
  - When `pending & ~done` == 0: `pkt_cnt`++. If an accept occurs the same cycle, load the new PHV; otherwise go to IDLE.
- Stall handling in DISPATCH:
  - `done` != 0 resets `stall_cnt` to 0.
  - `done` == 0 increments `stall_cnt`.
  - If STALL_LIMIT != 0, `done` == 0 and `stall_cnt` == STALL_LIMIT-1: `pending` <= 0, `timeout_cnt`++, go to IDLE. `phv_in_ready` is 0 in that cycle.
- Partial timeout: queues already served keep their copy; only unserved queues miss the PHV.
- Counters wrap modulo 2^CNT_WIDTH.
- Outputs with `phv_out_valid`==0 carry no obligation; `phv_out` holds its last value.

## Timing
- Reset (`aresetn`=1 at a clock edge):
  - state IDLE; `pending`, `stall_cnt`, `phv_out`, `phv_out_valid`, all counters = 0; `busy` = 0.
  - `phv_in_ready` = 0 while `aresetn`=1 and 1 in the first cycle after.
  - Reset mid-DISPATCH discards the held PHV without counting it.
- Latency: accept at edge N; `phv_out_valid` is asserted from cycle N+1.
- Unicast to a ready queue: one cycle of valid, then the next PHV is accepted in that same cycle. Sustained throughput is 1 PHV/cycle.
- Zero-mask PHVs are absorbed at 1/cycle with no output activity.
- Timeout: exactly STALL_LIMIT cycles of `phv_out_valid` with no handshake, then `phv_out_valid`=0 in the next cycle.
- Multicast completion takes max over the selected queues of that queue's wait.
- `phv_out_valid[i]` never drops before queue i's handshake, except at reset or timeout.

## Test plan
1. Unicast back-to-back: mask 4'b0001, all ready, 8 PHVs on consecutive cycles -> 8 handshakes on q0 only, one per cycle from cycle N+1; `pkt_cnt`=8; `phv_in_ready` stays 1.
2. Multicast skew: mask 4'b1011, q0 ready, q1 ready at +3, q3 ready at +5 -> q0 delivered at N+1, q1 at N+4, q3 at N+6; `phv_in_ready`=1 only in cycle N+6; `pkt_cnt`=1; q2 never valid.
3. Zero mask: 3 PHVs with mask 0 interleaved with one mask-4'b0100 PHV -> `drop_cnt`=3, `pkt_cnt`=1, only q2 sees traffic.
4. Timeout: STALL_LIMIT=16, mask 4'b0110, q1 ready, q2 never ready -> q1 delivered, `phv_out_valid[2]` high for 16 cycles after q1's delivery then low; `timeout_cnt`=1; next input accepted the following cycle.
5. Reset mid-dispatch: `aresetn`=1 while `pending`=4'b1000 -> `phv_out_valid`=0 next cycle, all counters 0, `phv_in_ready` 0 during reset and 1 after.
6. Upper mask bits ignored: C_NUM_QUEUES=2, PHV bits [141+:4]=4'b1100 -> treated as mask 0, `drop_cnt`=1.
